// File: rtl/result_deskew_collector_if.sv
// Row stream bundle for the result deskew collector: skewed lane input side
// and the aligned-row valid/ready output side.
interface result_deskew_collector_if #(
    parameter int DW    = 16,
    parameter int LANES = 4
);
    logic [LANES-1:0]    in_valid;
    logic [LANES*DW-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*DW-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/result_deskew_collector.sv
// Re-aligns the diagonally skewed result lanes of the systolic array, buffers
// aligned rows in a first-word fall-through FIFO and tracks tile completion.
module result_deskew_collector #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_start,
    input  logic [7:0]                i_num_rows,
    result_deskew_collector_if.slave  bus,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic                      o_skew_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = LANES * DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [LANES-1:0] w_al_vld;
    logic [RW-1:0]    w_al_dat;
    logic             w_row_ok;
    logic             w_row_part;

    logic [RW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    logic [7:0]       r_num_rows;
    logic [7:0]       r_rows_in;
    logic [7:0]       w_rows_nxt;
    logic             r_overflow;
    logic             r_skew_err;
    logic             r_done;

    logic             w_clear;
    logic             w_cnt_inc;
    logic             w_ovf_set;
    logic             w_skew_set;
    logic             w_done_nxt;

    // ---- deskew: lane k is delayed by LANES-1-k cycles, the last lane is a wire
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == LANES - 1) begin : g_pass
            assign w_al_vld[k]          = bus.in_valid[k];
            assign w_al_dat[k*DW +: DW] = bus.in_data[k*DW +: DW];
        end else begin : g_dly
            localparam int D = LANES - 1 - k;
            logic [D-1:0]  r_vld;
            logic [DW-1:0] r_dat [D];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_vld <= '0;
                    for (int s = 0; s < D; s++) r_dat[s] <= '0;
                end else begin
                    r_vld[0] <= bus.in_valid[k];
                    r_dat[0] <= bus.in_data[k*DW +: DW];
                    for (int s = 1; s < D; s++) begin
                        r_vld[s] <= r_vld[s-1];
                        r_dat[s] <= r_dat[s-1];
                    end
                end
            end

            assign w_al_vld[k]          = r_vld[D-1];
            assign w_al_dat[k*DW +: DW] = r_dat[D-1];
        end
    end

    assign w_row_ok   = &w_al_vld;
    assign w_row_part = (|w_al_vld) && !w_row_ok;

    // ---- FIFO status and read handshake
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_rd       = !w_empty && bus.out_ready;
    assign w_rows_nxt = r_rows_in + 8'd1;

    // ---- control FSM, next-state and per-cycle actions
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_wr        = 1'b0;
        w_cnt_inc   = 1'b0;
        w_ovf_set   = 1'b0;
        w_skew_set  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_clear = 1'b1;
                    if (i_num_rows == 8'd0) w_done_nxt  = 1'b1;
                    else                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_row_ok) begin
                    w_cnt_inc = 1'b1;
                    // a full FIFO still accepts when the head leaves this cycle
                    if (!w_full || w_rd) w_wr      = 1'b1;
                    else                 w_ovf_set = 1'b1;
                    if (w_rows_nxt == r_num_rows) w_state_nxt = S_DRAIN;
                end else if (w_row_part) begin
                    w_skew_set = 1'b1;
                end
            end
            S_DRAIN: begin
                // leave one cycle early so done and !busy coincide after the last read
                if (w_empty || (r_count == CW'(1) && w_rd)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---- tile counters, sticky flags and FIFO pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_num_rows <= '0;
            r_rows_in  <= '0;
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_clear) begin
                r_num_rows <= i_num_rows;
                r_rows_in  <= '0;
                r_overflow <= 1'b0;
                r_skew_err <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_cnt_inc)  r_rows_in  <= w_rows_nxt;
                if (w_ovf_set)  r_overflow <= 1'b1;
                if (w_skew_set) r_skew_err <= 1'b1;
                if (w_wr)       r_wr_ptr   <= r_wr_ptr + AW'(1);
                if (w_rd)       r_rd_ptr   <= r_rd_ptr + AW'(1);
                case ({w_wr, w_rd})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ---- row storage
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_al_dat;
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_skew_err    = r_skew_err;

endmodule

// File: doc/result_deskew_collector.md
# result_deskew_collector

Output-side counterpart of the systolic array's input skew buffers. It accepts the diagonally skewed result stream leaving the array's lanes, where lane k of a row arrives k cycles after lane 0. It re-aligns each row and buffers aligned rows in a small FIFO. Rows are presented downstream on a valid/ready interface, and the block signals completion of a tile of num_rows rows.

## Interface
- DW, 16, result width per lane
- LANES, 4, number of array output lanes
- DEPTH, 8, aligned-row FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; arms collection of a tile
- num_rows  in  8  rows expected in the tile; sampled on start
- in_valid  in  LANES  per-lane valid; bit k belongs to lane k
- in_data  in  LANES*DW  lane k at bits [k*DW +: DW]
- out_valid  out  1  aligned row available
- out_ready  in  1  downstream accepts row
- out_data  out  LANES*DW  aligned row, same lane packing as in_data
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse at tile completion
- overflow  out  1  sticky: aligned row dropped because FIFO full
- skew_err  out  1  sticky: partially valid aligned row seen

## Operation
- Deskew: lane k passes through LANES-1-k register stages, carrying both valid and data. Lane LANES-1 is combinational with zero stages. Delay lines shift every cycle regardless of busy.
- Aligned row = outputs of all delay lines in the same cycle. row_ok = all aligned valids set. row_partial = some, but not all, aligned valids set.
- States: IDLE, COLLECT, DRAIN.
- IDLE: start latches num_rows and clears the row counter, FIFO, overflow and skew_err.
  - num_rows≠0: go to COLLECT, busy=1.
  - num_rows=0: stay in IDLE and pulse done the next cycle.
- COLLECT:
  - On each row_ok cycle, rows_in increments.
  - The row is written to the FIFO unless the FIFO is full and no read happens that cycle. In that case the row is dropped and overflow is set.
  - row_partial sets skew_err and neither writes nor counts.
  - When rows_in reaches num_rows, go to DRAIN. Later valids are ignored.
- DRAIN: when the FIFO is empty, pulse done for one cycle, clear busy and return to IDLE.
- In IDLE, row_ok/row_partial are ignored: no write, no flag change.
- start while busy is ignored.
- FIFO is first-word fall-through. A read occurs on out_valid && out_ready. out_valid = FIFO not empty.
- Write and read in the same cycle are both honoured at any occupancy, including full.
- overflow and skew_err stay set until the next accepted start or reset.

## Timing
- Reset: out_valid=0, out_data=0, busy=0, done=0, overflow=0, skew_err=0, FIFO empty, delay lines cleared, state IDLE.
- busy rises the cycle after start.
- Row whose lane 0 is valid in cycle c, with lane k valid in cycle c+k:
  - Written at the end of cycle c+LANES-1.
  - out_valid=1 in cycle c+LANES if the FIFO was empty.
- out_data is stable while out_valid && !out_ready.
- Back-to-back rows (one row per cycle per lane) sustain one output row per cycle while out_ready=1.
- done is asserted in the cycle after the last row is read, with busy=0 in that same cycle.
- Reset mid-tile aborts immediately to the reset values. Data in flight is discarded.

## Test plan
- Single row, LANES=4: start num_rows=1. Lane k valid with value 0x10+k in cycle 2+k. Required: out_valid in cycle 6, out_data={0x13,0x12,0x11,0x10}. Accept with out_ready=1; done pulses in cycle 7 and busy falls.
- Streaming: num_rows=8, rows r=0..7 skewed, lane k value r*16+k, out_ready=1 throughout. Required: 8 consecutive out_valid cycles, in row order, correct values, overflow=0.
- Backpressure/overflow: DEPTH=8, num_rows=10, out_ready=0 until all rows are sent. Required: overflow=1, first 8 rows output intact, rows 9–10 dropped. done pulses after the 8th read.
- Full with simultaneous read: FIFO at 8 rows, out_ready=1 in the same cycle a new row aligns. Required: no overflow, occupancy stays 8.
- Skew error: lane 2 valid missing for one row. Required: skew_err=1, that row not output, rows_in not incremented, busy stays 1.
- Reset mid-tile: assert rstn=0 after 3 of 8 rows have been output. Required: all outputs 0 immediately. A new start with num_rows=0 gives a done pulse the next cycle.
